spi_reg_ctrl: RTL and testbench

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_pkg.sv | 28 ++
 rtl/sync_edge.sv | 35 +++
 rtl/spi_reg_ctrl.sv | 146 ++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register controller.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned CNT_SAT    = FRAME_BITS + 1;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

endpackage

// File: rtl/sync_edge.sv
// Flop-chain synchronizer with registered rise/fall pulses aligned to the synchronized level.
module sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              rise_q;
  logic              fall_q;

  // Edge pulses are computed from the last two stages so they appear with q_o, not a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RESET_VAL}};
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
      rise_q  <= chain_q[STAGES-2] & ~chain_q[STAGES-1];
      fall_q  <= ~chain_q[STAGES-2] & chain_q[STAGES-1];
    end
  end

  assign q_o    = chain_q[STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 write-only register file: 16-bit frames {rw, addr[6:0], data[7:0]}, five 8-bit registers.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_done,
  output logic       txn_err
);

  logic sclk_lvl_unused, sclk_fall_unused, sclk_rise;
  logic copi_s, copi_rise_unused, copi_fall_unused;
  logic ncs_s, ncs_rise, ncs_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk),
    .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d_i(copi),
    .q_o(copi_s), .rise_o(copi_rise_unused), .fall_o(copi_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d_i(ncs),
    .q_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]       out_lo_q, out_lo_d, out_hi_q, out_hi_d;
  logic [DATA_W-1:0]       pwm_lo_q, pwm_lo_d, pwm_hi_q, pwm_hi_d;
  logic [DATA_W-1:0]       duty_q, duty_d;
  logic                    done_q, done_d, err_q, err_d;
  logic [SYNC_STAGES:0]    settle_q, settle_d;
  logic                    armed_q, armed_d;
  frame_t                  frame_c;

  assign frame_c = frame_t'(shift_q);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    out_lo_d = out_lo_q;
    out_hi_d = out_hi_q;
    pwm_lo_d = pwm_lo_q;
    pwm_hi_d = pwm_hi_q;
    duty_d   = duty_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    settle_d = {settle_q[SYNC_STAGES-1:0], 1'b1};
    // Arm only after ncs has been seen high once the synchronizer is flushed, so a frame
    // already in progress at reset release is never accepted.
    armed_d  = armed_q | (settle_q[SYNC_STAGES] & ncs_s);

    unique case (state_q)
      ST_IDLE: begin
        if (ncs_fall && armed_q) begin
          state_d = ST_SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (ncs_rise) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
          if (cnt_q != CNT_W'(CNT_SAT)) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if ((cnt_q == CNT_W'(FRAME_BITS)) && (32'(frame_c.addr) <= MAX_ADDR)) begin
          if (frame_c.rw) begin
            done_d = 1'b1;
            case (frame_c.addr)
              ADDR_EN_OUT_7_0:  out_lo_d = frame_c.data;
              ADDR_EN_OUT_15_8: out_hi_d = frame_c.data;
              ADDR_EN_PWM_7_0:  pwm_lo_d = frame_c.data;
              ADDR_EN_PWM_15_8: pwm_hi_d = frame_c.data;
              ADDR_PWM_DUTY:    duty_d   = frame_c.data;
              default: ;
            endcase
          end
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      out_lo_q <= '0;
      out_hi_q <= '0;
      pwm_lo_q <= '0;
      pwm_hi_q <= '0;
      duty_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      out_lo_q <= out_lo_d;
      out_hi_q <= out_hi_d;
      pwm_lo_q <= pwm_lo_d;
      pwm_hi_q <= pwm_hi_d;
      duty_q   <= duty_d;
      done_q   <= done_d;
      err_q    <= err_d;
      settle_q <= settle_d;
      armed_q  <= armed_d;
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign txn_done        = done_q;
  assign txn_err         = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: stimulus queues expected pulses, a monitor checks them.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       txn_done, txn_err;

  spi_reg_ctrl #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .txn_done(txn_done), .txn_err(txn_err)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] K_DONE = 2'b10;
  localparam logic [1:0] K_ERR  = 2'b01;

  typedef struct {
    logic [1:0]  kind;
    logic [39:0] regs;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [39:0] regs_now();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Monitor: every pulse must match the oldest queued expectation, including register state.
  always @(negedge clk) begin
    if (rst_n && (txn_done || txn_err)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse actual done=%b err=%b required none", txn_done, txn_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_kind"}, 64'({txn_done, txn_err}), 64'(e.kind));
        check({e.name, "_regs"}, 64'(regs_now()), 64'(e.regs));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [1:0] kind, input logic [39:0] regs, input string name);
    exp_t e;
    e.kind = kind;
    e.regs = regs;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] v, input int n);
    ncs = 1'b0;
    wait_clk(4);
    shift_bits(v, n);
    wait_clk(4);
    ncs = 1'b1;
    wait_clk(10);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      wait_clk(1);
      k++;
    end
    check({name, "_drain"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    wait_clk(3);
    check("reset_regs", 64'(regs_now()), 64'(0));
    check("reset_pulses", 64'({txn_done, txn_err}), 64'(0));
    rst_n = 1'b1;
    wait_clk(10);
    check("post_reset_regs", 64'(regs_now()), 64'(0));

    // Duty register write.
    push(K_DONE, 40'h80_00_00_00_00, "wr_duty");
    frame(32'h8480, 16);
    drain("wr_duty");

    // Back-to-back writes to 0x00 and 0x02.
    push(K_DONE, 40'h80_00_00_00_F0, "wr_out_lo");
    push(K_DONE, 40'h80_00_0F_00_F0, "wr_pwm_lo");
    frame(32'h80F0, 16);
    frame(32'h820F, 16);
    drain("b2b");

    // Address above MAX_ADDR.
    push(K_ERR, 40'h80_00_0F_00_F0, "bad_addr");
    frame(32'h85AA, 16);
    drain("bad_addr");

    // Short and long frames.
    push(K_ERR, 40'h80_00_0F_00_F0, "short15");
    push(K_ERR, 40'h80_00_0F_00_F0, "long17");
    frame(32'h0000_0011, 15);
    frame(32'h0001_8011, 17);
    drain("len");

    // Read frame is silently dropped.
    frame(32'h0100, 16);
    wait_clk(10);
    check("read_regs", 64'(regs_now()), 64'(40'h80_00_0F_00_F0));

    // Reset mid-frame, released with ncs low, remaining bits clocked in.
    ncs = 1'b0;
    wait_clk(4);
    shift_bits(32'h81, 8);
    wait_clk(2);
    rst_n = 1'b0;
    wait_clk(2);
    check("rst_mid_regs", 64'(regs_now()), 64'(0));
    rst_n = 1'b1;
    wait_clk(4);
    shift_bits(32'h55, 8);
    wait_clk(4);
    ncs = 1'b1;
    wait_clk(20);
    check("rst_tail_regs", 64'(regs_now()), 64'(0));
    check("rst_tail_queue", 64'(exp_q.size()), 64'(0));

    push(K_DONE, 40'h00_00_00_33_00, "wr_after_rst");
    frame(32'h8133, 16);
    drain("wr_after_rst");

    wait_clk(10);
    check("final_regs", 64'(regs_now()), 64'(40'h00_00_00_33_00));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
